// File: rtl/cam_ctrl_pkg.sv
// Shared types and constants for the camera frame controller.
// FSM state encodings, RGB565 pixel layout and address-width helper.
package cam_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ARM     = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_DRAIN   = 3'd3;
  localparam state_t ST_RELEASE = 3'd4;

  localparam int BYTE_W   = 8;
  localparam int RGB565_W = 16;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_R_W   = 5;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_G_W   = 6;
  localparam int RGB_B_LSB = 0;
  localparam int RGB_B_W   = 5;
  // First byte of a pixel lands in the upper half of the RGB565 word.
  localparam int RGB_HI_LSB = 8;

  function automatic int addr_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/cam_frame_ctrl_if.sv
// Frame request, capture-FIFO and frame-buffer write signals of the controller.
interface cam_frame_ctrl_if #(
  parameter int ADDR_W = 15
);
  import cam_ctrl_pkg::*;

  logic                frame_req;
  logic                frame_busy;
  logic                frame_done;
  logic                frame_err;
  logic                cam_start_en;
  logic                cam_get_data;
  logic [BYTE_W-1:0]   cam_data;
  logic                cam_data_ready;
  logic                cam_read_busy;
  logic                cam_vsync_trig;
  logic                pix_we;
  logic [ADDR_W-1:0]   pix_addr;
  logic [RGB565_W-1:0] pix_data;

  modport master (
    input  frame_req, cam_data, cam_data_ready, cam_read_busy, cam_vsync_trig,
    output frame_busy, frame_done, frame_err, cam_start_en, cam_get_data,
           pix_we, pix_addr, pix_data
  );

  modport slave (
    output frame_req, cam_data, cam_data_ready, cam_read_busy, cam_vsync_trig,
    input  frame_busy, frame_done, frame_err, cam_start_en, cam_get_data,
           pix_we, pix_addr, pix_data
  );

endinterface

// File: rtl/cam_pixel_pack.sv
// Packs byte pairs from the capture FIFO into RGB565 frame-buffer writes.
// Writes past the last pixel are dropped and flagged as overflow.
module cam_pixel_pack
  import cam_ctrl_pkg::*;
#(
  parameter int NPIX   = 19200,
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 15
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clr,
  input  logic                byte_vld,
  input  logic [BYTE_W-1:0]   byte_data,
  output logic                pix_we,
  output logic [ADDR_W-1:0]   pix_addr,
  output logic [RGB565_W-1:0] pix_data,
  output logic                phase,
  output logic [CNT_W-1:0]    pix_cnt,
  output logic                ovf
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NPIX);

  logic                phase_r;
  logic [BYTE_W-1:0]   hi_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                ovf_r;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [RGB565_W-1:0] data_r;

  // Byte phase tracking, pixel assembly and saturating pixel counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_r <= 1'b0;
      hi_r    <= {BYTE_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      data_r  <= {RGB565_W{1'b0}};
    end else if (clr) begin
      phase_r <= 1'b0;
      hi_r    <= {BYTE_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
    end else begin
      we_r <= 1'b0;
      if (byte_vld) begin
        phase_r <= ~phase_r;
        if (!phase_r) begin
          hi_r <= byte_data;
        end else if (cnt_r == CNT_FULL) begin
          // Frame already full: address holds at the last pixel.
          ovf_r <= 1'b1;
        end else begin
          we_r   <= 1'b1;
          addr_r <= cnt_r[ADDR_W-1:0];
          data_r <= {hi_r, byte_data};
          cnt_r  <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign pix_we   = we_r;
  assign pix_addr = addr_r;
  assign pix_data = data_r;
  assign phase    = phase_r;
  assign pix_cnt  = cnt_r;
  assign ovf      = ovf_r;

endmodule

// File: rtl/cam_frame_ctrl.sv
// Single-frame capture sequencer: arms the camera, drains its FIFO into the
// frame buffer and reports done/error with a frame-level timeout.
module cam_frame_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int TIMEOUT_CYC = 4_000_000,
  parameter int DRAIN_IDLE  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  cam_frame_ctrl_if.master bus
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ADDR_W = addr_w(NPIX);
  localparam int CNT_W  = $clog2(NPIX + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int IDLE_W = $clog2(DRAIN_IDLE + 1);

  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_IDLE - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(NPIX);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [TMO_W-1:0]    tmo_r;
  logic [IDLE_W-1:0]   idle_r;
  logic                to_err_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
  logic                start_en_r;
  logic                get_d_r;

  logic                active_s;
  logic                tmo_hit_s;
  logic                get_s;
  logic                start_s;
  logic                exit_s;
  logic                frame_bad_s;

  logic                pix_we_s;
  logic [ADDR_W-1:0]   pix_addr_s;
  logic [RGB565_W-1:0] pix_data_s;
  logic                phase_s;
  logic [CNT_W-1:0]    cnt_s;
  logic                ovf_s;

  // Status decode shared by the FSM and output registers.
  always_comb begin
    active_s    = (state_r == ST_ARM) || (state_r == ST_CAPTURE) || (state_r == ST_DRAIN);
    tmo_hit_s   = active_s && (tmo_r == TMO_LAST);
    get_s       = ((state_r == ST_CAPTURE) || (state_r == ST_DRAIN)) && bus.cam_data_ready;
    start_s     = (state_r == ST_IDLE) && bus.frame_req;
    exit_s      = (state_r == ST_RELEASE) && !bus.cam_read_busy;
    frame_bad_s = to_err_r || ovf_s || phase_s || (cnt_s != CNT_FULL);
  end

  // Next-state logic; the timeout overrides every other exit.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.frame_req) begin
          state_nxt_s = ST_ARM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (tmo_hit_s) begin
          state_nxt_s = ST_RELEASE;
        end else if (bus.cam_read_busy) begin
          state_nxt_s = ST_CAPTURE;
        end else begin
          state_nxt_s = ST_ARM;
        end
      end
      ST_CAPTURE: begin
        if (tmo_hit_s) begin
          state_nxt_s = ST_RELEASE;
        end else if (bus.cam_vsync_trig) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (tmo_hit_s) begin
          state_nxt_s = ST_RELEASE;
        end else if (!bus.cam_data_ready && (idle_r == IDLE_LAST)) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_RELEASE: begin
        if (!bus.cam_read_busy) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, timeout and drain-idle counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      tmo_r    <= {TMO_W{1'b0}};
      idle_r   <= {IDLE_W{1'b0}};
      to_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (start_s) begin
        tmo_r    <= {TMO_W{1'b0}};
        to_err_r <= 1'b0;
      end else if (active_s) begin
        tmo_r <= tmo_r + TMO_W'(1);
        if (tmo_hit_s) begin
          to_err_r <= 1'b1;
        end else begin
          to_err_r <= to_err_r;
        end
      end else begin
        tmo_r <= tmo_r;
      end
      if ((state_r != ST_DRAIN) || bus.cam_data_ready) begin
        idle_r <= {IDLE_W{1'b0}};
      end else begin
        idle_r <= idle_r + IDLE_W'(1);
      end
    end
  end

  // Registered handshake outputs and end-of-frame pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      start_en_r <= 1'b0;
      get_d_r    <= 1'b0;
    end else begin
      start_en_r <= (state_nxt_s == ST_ARM) || (state_nxt_s == ST_CAPTURE);
      get_d_r    <= get_s;
      done_r     <= exit_s && !frame_bad_s;
      err_r      <= exit_s && frame_bad_s;
      if (start_s) begin
        busy_r <= 1'b1;
      end else if (exit_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  cam_pixel_pack #(
    .NPIX   (NPIX),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_pack (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (start_s),
    .byte_vld  (get_d_r),
    .byte_data (bus.cam_data),
    .pix_we    (pix_we_s),
    .pix_addr  (pix_addr_s),
    .pix_data  (pix_data_s),
    .phase     (phase_s),
    .pix_cnt   (cnt_s),
    .ovf       (ovf_s)
  );

  assign bus.frame_busy   = busy_r;
  assign bus.frame_done   = done_r;
  assign bus.frame_err    = err_r;
  assign bus.cam_start_en = start_en_r;
  assign bus.cam_get_data = get_s;
  assign bus.pix_we       = pix_we_s;
  assign bus.pix_addr     = pix_addr_s;
  assign bus.pix_data     = pix_data_s;

endmodule

// File: tb/tb_cam_frame_ctrl.sv
// Directed bench for cam_frame_ctrl with a small byte-FIFO camera model.
module tb_cam_frame_ctrl;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int TMO   = 1000;
  localparam int DRN   = 4;
  localparam int NPIX  = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cam_frame_ctrl_if #(.ADDR_W(3)) bus ();

  cam_frame_ctrl #(
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .TIMEOUT_CYC (TMO),
    .DRAIN_IDLE  (DRN)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] q[$];
  logic [7:0] pend;
  bit         have_pend;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk_eq({tag, "_busy"},  32'(bus.frame_busy),   32'd0);
    chk_eq({tag, "_done"},  32'(bus.frame_done),   32'd0);
    chk_eq({tag, "_err"},   32'(bus.frame_err),    32'd0);
    chk_eq({tag, "_start"}, 32'(bus.cam_start_en), 32'd0);
    chk_eq({tag, "_get"},   32'(bus.cam_get_data), 32'd0);
    chk_eq({tag, "_we"},    32'(bus.pix_we),       32'd0);
    chk_eq({tag, "_addr"},  32'(bus.pix_addr),     32'd0);
    chk_eq({tag, "_data"},  32'(bus.pix_data),     32'd0);
  endtask

  task automatic model_clear();
    q.delete();
    have_pend          = 1'b0;
    bus.frame_req      = 1'b0;
    bus.cam_data       = 8'h00;
    bus.cam_data_ready = 1'b0;
    bus.cam_read_busy  = 1'b0;
    bus.cam_vsync_trig = 1'b0;
  endtask

  // nbytes bytes 0,1,2.. are queued; req_at/rst_at: write count at which a
  // second request or a reset is injected (-1 = never).
  task automatic run_frame(input string name, input int nbytes, input bit busy_rise,
                           input int req_at, input int rst_at, input int exp_we,
                           input bit exp_done, input int exp_start_cyc);
    int nw = 0, nd = 0, ne = 0, n_se = 0, cyc;
    bit fin = 1'b0, rst_hit = 1'b0, req_sent = 1'b0, vs_done = 1'b0;
    logic [15:0] exp_pix;
    for (int i = 0; i < nbytes; i++) q.push_back(8'(i));
    for (cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      if (bus.pix_we) begin
        if (nw < NPIX) begin
          exp_pix = {8'(2 * nw), 8'(2 * nw + 1)};
          chk_eq({name, "_addr"}, 32'(bus.pix_addr), 32'(nw));
          chk_eq({name, "_pix"},  32'(bus.pix_data), 32'(exp_pix));
        end else begin
          chk_eq({name, "_extra_write"}, 32'(nw), 32'(NPIX - 1));
        end
        nw++;
      end
      if (bus.cam_start_en) n_se++;
      if (cyc == 1) chk_eq({name, "_busy_after_req"}, 32'(bus.frame_busy), 32'd1);
      if (bus.frame_done || bus.frame_err) begin
        nd  = nd + int'(bus.frame_done);
        ne  = ne + int'(bus.frame_err);
        chk_eq({name, "_busy_at_end"}, 32'(bus.frame_busy), 32'd0);
        fin = 1'b1;
      end
      if (rst_at >= 0 && nw == rst_at) begin
        resetn = 1'b0;
        #1;
        chk_outputs_zero({name, "_rst"});
        rst_hit = 1'b1;
        fin     = 1'b1;
      end else begin
        bus.frame_req = (cyc == 0);
        if (req_at >= 0 && nw == req_at && !req_sent) begin
          bus.frame_req = 1'b1;
          req_sent      = 1'b1;
        end
        if (have_pend) begin
          bus.cam_data = pend;
          have_pend    = 1'b0;
        end
        if (busy_rise && bus.cam_start_en && !vs_done) bus.cam_read_busy = 1'b1;
        bus.cam_data_ready = (q.size() > 0);
        if (bus.cam_read_busy && !bus.cam_data_ready && !vs_done) begin
          bus.cam_vsync_trig = 1'b1;
          bus.cam_read_busy  = 1'b0;
          vs_done            = 1'b1;
        end
        #1;
        if (bus.cam_get_data && q.size() > 0) begin
          pend      = q.pop_front();
          have_pend = 1'b1;
        end
      end
    end
    if (rst_hit) begin
      @(negedge clk);
      resetn = 1'b1;
      model_clear();
    end else begin
      chk_eq({name, "_finished"},  32'(fin), 32'd1);
      chk_eq({name, "_writes"},    32'(nw),  32'(exp_we));
      chk_eq({name, "_done_cnt"},  32'(nd),  32'(exp_done));
      chk_eq({name, "_err_cnt"},   32'(ne),  32'(!exp_done));
      if (exp_start_cyc >= 0) chk_eq({name, "_start_cycles"}, 32'(n_se), 32'(exp_start_cyc));
      model_clear();
      nd = 0;
      ne = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        nd = nd + int'(bus.frame_done) + int'(bus.frame_err) + int'(bus.frame_busy);
      end
      chk_eq({name, "_quiet_after"}, 32'(nd), 32'd0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("full16",   16, 1'b1, -1, -1, 8, 1'b1, -1);
    run_frame("short15",  15, 1'b1, -1, -1, 7, 1'b0, -1);
    run_frame("over20",   20, 1'b1, -1, -1, 8, 1'b0, -1);
    run_frame("timeout",   0, 1'b0, -1, -1, 0, 1'b0, TMO);
    run_frame("dup_req",  16, 1'b1,  3, -1, 8, 1'b1, -1);
    run_frame("mid_rst",  16, 1'b1, -1,  3, 0, 1'b0, -1);
    run_frame("after_rst",16, 1'b1, -1, -1, 8, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cam_frame_ctrl.md
CAM_FRAME_CTRL -- requirements
Module: cam_frame_ctrl

Interface
REQ-001 Parameter IMG_W, default 160, pixels per row.
REQ-002 Parameter IMG_H, default 120, rows per frame.
REQ-003 Parameter TIMEOUT_CYC, default 4_000_000, clk cycles allowed from arm to frame end before abort.
REQ-004 Parameter DRAIN_IDLE, default 4, consecutive empty cycles that end the drain.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  system clock; all logic on its rising edge.
REQ-007 resetn  in  1  asynchronous active-low reset.
REQ-008 frame_req  in  1  single-cycle request to capture one frame.
REQ-009 frame_busy  out  1  high from accepted request until frame_done/frame_err pulse.
REQ-010 frame_done  out  1  one-cycle pulse: frame completed with exactly IMG_W*IMG_H pixels.
REQ-011 frame_err  out  1  one-cycle pulse: frame ended on timeout, pixel-count mismatch or odd byte count.
REQ-012 cam_start_en  out  1  arm request to the camera capture path.
REQ-013 cam_get_data  out  1  FIFO read strobe; byte valid on cam_data the following cycle.
REQ-014 cam_data  in  8  byte from the capture FIFO.
REQ-015 cam_data_ready  in  1  capture FIFO non-empty.
REQ-016 cam_read_busy  in  1  capture path busy (already synchronized to clk).
REQ-017 cam_vsync_trig  in  1  capture path reached end of frame (synchronized level).
REQ-018 pix_we  out  1  pixel write strobe to frame buffer.
REQ-019 pix_addr  out  clog2(IMG_W*IMG_H)  row-major pixel address.
REQ-020 pix_data  out  16  RGB565 pixel.

Function
REQ-021 States: IDLE, ARM, CAPTURE, DRAIN, RELEASE.
REQ-022 IDLE: frame_req=1 -> ARM; clear pixel count, address, byte phase, timeout counter; frame_busy=1 next cycle.
REQ-023 ARM: cam_start_en=1; cam_read_busy=1 -> CAPTURE.
REQ-024 CAPTURE: cam_start_en=1; cam_get_data=cam_data_ready; cam_vsync_trig=1 -> DRAIN.
REQ-025 DRAIN: cam_start_en=0; cam_get_data=cam_data_ready; DRAIN_IDLE consecutive cycles with cam_data_ready=0 -> RELEASE.
REQ-026 RELEASE: cam_get_data=0; cam_read_busy=0 -> IDLE, pulsing frame_done or frame_err in that transition cycle; frame_busy=0 the same cycle.
REQ-027 Each byte returned (cycle after cam_get_data=1) toggles byte phase: phase 0 byte -> pix_data[15:8], phase 1 byte -> pix_data[7:0] with pix_we=1 that cycle.
REQ-028 pix_addr equals pixel count at the write; pixel count increments after each write.
REQ-029 Writes beyond IMG_W*IMG_H-1 are suppressed (pix_we=0, address saturates) and mark the frame in error.
REQ-030 At RELEASE exit: frame_err if count != IMG_W*IMG_H, byte phase = 1, or timeout; else frame_done; never both.
REQ-031 Timeout counter runs in ARM, CAPTURE, DRAIN; reaching TIMEOUT_CYC forces RELEASE with error latched, cam_start_en=0.
REQ-032 frame_req while frame_busy=1 is ignored, not queued.
REQ-033 cam_vsync_trig and last byte in same cycle: byte is still consumed; transition to DRAIN unaffected.

Reset
REQ-034 resetn=0 -> state IDLE; cam_start_en, cam_get_data, pix_we, frame_busy, frame_done, frame_err = 0; pix_addr=0; pix_data=0; counters and error flag cleared, including mid-frame.

Structure
REQ-035 cam_ctrl_pkg holds the state enum and RGB565 width/field constants.
REQ-036 Byte-to-pixel packing (REQ-027..029) is one sub-module, cam_pixel_pack; FSM and timeout stay in cam_frame_ctrl.

Verification (IMG_W=4, IMG_H=2, TIMEOUT_CYC=1000)
REQ-037 16 bytes 0x00..0x0F then vsync_trig -> 8 writes, addr 0..7, data 0x0001,0x0203,...,0x0E0F; one frame_done; no frame_err.
REQ-038 15 bytes -> 7 writes; frame_err pulse; frame_done stays 0.
REQ-039 20 bytes -> exactly 8 writes, addr never exceeds 7; frame_err pulse.
REQ-040 cam_read_busy never rises -> cam_start_en drops at cycle 1000 after arm; frame_err after busy low; frame_busy=0.
REQ-041 frame_req pulsed again mid-CAPTURE -> ignored; exactly one done pulse.
REQ-042 resetn low mid-CAPTURE -> all outputs 0 at once; new frame_req afterward captures a clean 8-pixel frame from addr 0.
